// File: rtl/lite2s_pkg.sv
// Shared definitions for the AXI-Lite to AXI-Stream packetizer: register map,
// CTRL/STATUS bit positions, FSM encoding and response codes.
package lite2s_pkg;

   localparam int unsigned OFF_CTRL   = 32'h00;
   localparam int unsigned OFF_STATUS = 32'h04;
   localparam int unsigned OFF_DATA   = 32'h08;
   localparam int unsigned OFF_START  = 32'h0C;

   localparam int unsigned CTRL_ENABLE     = 0;
   localparam int unsigned CTRL_AUTO_START = 1;
   localparam int unsigned CTRL_IE_DONE    = 2;
   localparam int unsigned CTRL_IE_OVF     = 3;
   localparam int unsigned CTRL_FLUSH      = 4;
   localparam int unsigned CTRL_LEN_LSB    = 8;

   localparam int unsigned STAT_BUSY      = 0;
   localparam int unsigned STAT_OVF       = 1;
   localparam int unsigned STAT_EMPTY     = 2;
   localparam int unsigned STAT_FULL      = 3;
   localparam int unsigned STAT_PENDING   = 4;
   localparam int unsigned STAT_DONE      = 5;
   localparam int unsigned STAT_LEVEL_LSB = 8;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

endpackage

// File: rtl/lite2s_fifo.sv
// First-word-fall-through FIFO for the packetizer; flush has priority over
// push and pop, and a full FIFO rejects pushes even when popping.
module lite2s_fifo #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_level == (AW+1)'(DEPTH));
   assign empty  = (r_level == '0);
   assign level  = r_level;
   assign dout   = r_mem[r_rptr];
   assign w_push = push & ~full & ~flush;
   assign w_pop  = pop & ~empty & ~flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else if (flush) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_level <= '0;
      end else begin
         // Pointers are AW bits wide, so wrap is modulo DEPTH for free.
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= din;
   end

endmodule

// File: rtl/axi_lite2stream_packetizer.sv
// AXI-Lite slave that queues written words in a FIFO and emits them as
// AXI-Stream packets of programmable length with TLAST on the final beat.
module axi_lite2stream_packetizer
   import lite2s_pkg::*;
#(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
   parameter int unsigned FIFO_DEPTH         = 16
) (
   input  logic                              S_AXI_ACLK,
   input  logic                              S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
   input  logic [2:0]                        S_AXI_AWPROT,
   input  logic                              S_AXI_AWVALID,
   output logic                              S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
   input  logic                              S_AXI_WVALID,
   output logic                              S_AXI_WREADY,
   output logic [1:0]                        S_AXI_BRESP,
   output logic                              S_AXI_BVALID,
   input  logic                              S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
   input  logic [2:0]                        S_AXI_ARPROT,
   input  logic                              S_AXI_ARVALID,
   output logic                              S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
   output logic [1:0]                        S_AXI_RRESP,
   output logic                              S_AXI_RVALID,
   input  logic                              S_AXI_RREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]     M_AXIS_TDATA,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic                              M_AXIS_TLAST,
   output logic                              irq
);

   localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
   localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

   state_t          r_state;
   state_t          w_state_nxt;

   logic            r_awready;
   logic            r_bvalid;
   logic            r_arready;
   logic            r_rvalid;
   logic [DW-1:0]   r_rdata;

   logic            r_enable;
   logic            r_auto;
   logic            r_ie_done;
   logic            r_ie_ovf;
   logic [7:0]      r_len;
   logic            r_ovf;
   logic            r_done;
   logic            r_pending;
   logic            r_flush_pend;
   logic [8:0]      r_lat_len;
   logic [8:0]      r_beat;

   logic            w_wr_en;
   logic [AW-1:0]   w_wr_off;
   logic [AW-1:0]   w_rd_off;
   logic            w_wr_ctrl;
   logic            w_wr_status;
   logic            w_wr_data;
   logic            w_wr_start;
   logic            w_flush_req;
   logic            w_flush_now;
   logic            w_idle;
   logic            w_send;
   logic            w_launch;
   logic            w_beat_hs;
   logic            w_last;
   logic            w_done_set;
   logic            w_ovf_set;
   logic [8:0]      w_eff_len;
   logic [DW-1:0]   w_fifo_dout;
   logic [LW-1:0]   w_level;
   logic            w_full;
   logic            w_empty;
   logic [DW-1:0]   w_ctrl_rd;
   logic [DW-1:0]   w_status_rd;
   logic [DW-1:0]   w_rdata;
   logic            w_unused;

   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                       S_AXI_ARADDR[1:0], S_AXI_WSTRB};

   // ---------------- AXI-Lite handshakes ----------------
   assign w_wr_en     = r_awready & S_AXI_AWVALID & S_AXI_WVALID;
   assign w_wr_off    = {S_AXI_AWADDR[AW-1:2], 2'b00};
   assign w_rd_off    = {S_AXI_ARADDR[AW-1:2], 2'b00};
   assign w_wr_ctrl   = w_wr_en & (w_wr_off == AW'(OFF_CTRL));
   assign w_wr_status = w_wr_en & (w_wr_off == AW'(OFF_STATUS));
   assign w_wr_data   = w_wr_en & (w_wr_off == AW'(OFF_DATA));
   assign w_wr_start  = w_wr_en & (w_wr_off == AW'(OFF_START));

   assign S_AXI_AWREADY = r_awready;
   assign S_AXI_WREADY  = r_awready;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = RESP_OKAY;
   assign S_AXI_ARREADY = r_arready;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RDATA   = r_rdata;
   assign S_AXI_RRESP   = RESP_OKAY;

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_awready <= 1'b0;
         r_bvalid  <= 1'b0;
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
      end else begin
         r_awready <= 1'b0;
         if (!r_awready && !r_bvalid && S_AXI_AWVALID && S_AXI_WVALID)
            r_awready <= 1'b1;
         if (w_wr_en)
            r_bvalid <= 1'b1;
         else if (r_bvalid && S_AXI_BREADY)
            r_bvalid <= 1'b0;

         r_arready <= 1'b0;
         if (!r_arready && !r_rvalid && S_AXI_ARVALID)
            r_arready <= 1'b1;
         if (r_arready && S_AXI_ARVALID) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rdata;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // ---------------- Read mux ----------------
   always_comb begin
      w_ctrl_rd                          = '0;
      w_ctrl_rd[CTRL_ENABLE]             = r_enable;
      w_ctrl_rd[CTRL_AUTO_START]         = r_auto;
      w_ctrl_rd[CTRL_IE_DONE]            = r_ie_done;
      w_ctrl_rd[CTRL_IE_OVF]             = r_ie_ovf;
      w_ctrl_rd[CTRL_LEN_LSB +: 8]       = r_len;

      w_status_rd                        = '0;
      w_status_rd[STAT_BUSY]             = w_send;
      w_status_rd[STAT_OVF]              = r_ovf;
      w_status_rd[STAT_EMPTY]            = w_empty;
      w_status_rd[STAT_FULL]             = w_full;
      w_status_rd[STAT_PENDING]          = r_pending;
      w_status_rd[STAT_DONE]             = r_done;
      w_status_rd[STAT_LEVEL_LSB +: LW]  = w_level;

      w_rdata = '0;
      if (w_rd_off == AW'(OFF_CTRL))
         w_rdata = w_ctrl_rd;
      else if (w_rd_off == AW'(OFF_STATUS))
         w_rdata = w_status_rd;
   end

   // ---------------- Packet control ----------------
   assign w_idle      = (r_state == ST_IDLE);
   assign w_send      = (r_state == ST_SEND);
   assign w_flush_req = w_wr_ctrl & S_AXI_WSTRB[0] & S_AXI_WDATA[CTRL_FLUSH];
   // A flush written mid-packet waits in r_flush_pend for the first IDLE cycle.
   assign w_flush_now = w_idle & (r_flush_pend | w_flush_req);
   assign w_ovf_set   = w_wr_data & w_full & ~w_flush_now;

   always_comb begin
      if (r_len == 8'd0)
         w_eff_len = 9'd1;
      else if ({1'b0, r_len} > 9'(FIFO_DEPTH))
         w_eff_len = 9'(FIFO_DEPTH);
      else
         w_eff_len = {1'b0, r_len};
   end

   assign w_launch   = w_idle & r_enable & (r_pending | r_auto) & ~w_flush_now &
                       (9'(w_level) >= w_eff_len);
   assign w_beat_hs  = w_send & M_AXIS_TREADY;
   assign w_last     = w_send & (r_beat == r_lat_len - 9'd1);
   assign w_done_set = w_beat_hs & w_last;

   always_comb begin
      w_state_nxt   = r_state;
      M_AXIS_TVALID = 1'b0;
      M_AXIS_TLAST  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_launch) w_state_nxt = ST_SEND;
         end
         ST_SEND: begin
            M_AXIS_TVALID = 1'b1;
            M_AXIS_TLAST  = w_last;
            if (w_done_set) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign M_AXIS_TDATA = w_fifo_dout;
   assign irq          = (r_done & r_ie_done) | (r_ovf & r_ie_ovf);

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         r_state      <= ST_IDLE;
         r_enable     <= 1'b0;
         r_auto       <= 1'b0;
         r_ie_done    <= 1'b0;
         r_ie_ovf     <= 1'b0;
         r_len        <= '0;
         r_ovf        <= 1'b0;
         r_done       <= 1'b0;
         r_pending    <= 1'b0;
         r_flush_pend <= 1'b0;
         r_lat_len    <= '0;
         r_beat       <= '0;
      end else begin
         r_state <= w_state_nxt;

         if (w_wr_ctrl && S_AXI_WSTRB[0]) begin
            r_enable  <= S_AXI_WDATA[CTRL_ENABLE];
            r_auto    <= S_AXI_WDATA[CTRL_AUTO_START];
            r_ie_done <= S_AXI_WDATA[CTRL_IE_DONE];
            r_ie_ovf  <= S_AXI_WDATA[CTRL_IE_OVF];
         end
         if (w_wr_ctrl && S_AXI_WSTRB[1])
            r_len <= S_AXI_WDATA[CTRL_LEN_LSB +: 8];

         // Hardware set beats a coincident write-1-to-clear.
         r_ovf  <= (r_ovf  & ~(w_wr_status & S_AXI_WDATA[STAT_OVF]))  | w_ovf_set;
         r_done <= (r_done & ~(w_wr_status & S_AXI_WDATA[STAT_DONE])) | w_done_set;

         if (w_wr_start)
            r_pending <= 1'b1;
         else if (w_launch || w_flush_now)
            r_pending <= 1'b0;

         if (w_flush_now)
            r_flush_pend <= 1'b0;
         else if (w_flush_req)
            r_flush_pend <= 1'b1;

         if (w_launch) begin
            r_lat_len <= w_eff_len;
            r_beat    <= '0;
         end else if (w_beat_hs) begin
            r_beat <= r_beat + 9'd1;
         end
      end
   end

   lite2s_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clk   (S_AXI_ACLK),
      .rst_n (S_AXI_ARESETN),
      .push  (w_wr_data),
      .pop   (w_beat_hs),
      .flush (w_flush_now),
      .din   (S_AXI_WDATA),
      .dout  (w_fifo_dout),
      .level (w_level),
      .full  (w_full),
      .empty (w_empty)
   );

endmodule

// File: tb/tb_axi_lite2stream_packetizer.sv
// Directed bench for axi_lite2stream_packetizer: register accesses, packet
// framing against a beat scoreboard, overflow, deferred start, flush and reset.
module tb_axi_lite2stream_packetizer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  awaddr = '0;
   logic [2:0]  awprot = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [4:0]  araddr = '0;
   logic [2:0]  arprot = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready = 1'b1;
   logic        tlast;
   logic        irq;

   int          vectors = 0;
   int          miscompares = 0;
   logic [32:0] sb[$];

   always #5 clk = ~clk;

   axi_lite2stream_packetizer #(
      .C_S_AXI_DATA_WIDTH (32),
      .C_S_AXI_ADDR_WIDTH (5),
      .FIFO_DEPTH         (16)
   ) dut (
      .S_AXI_ACLK    (clk),
      .S_AXI_ARESETN (rst_n),
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .M_AXIS_TDATA  (tdata),
      .M_AXIS_TVALID (tvalid),
      .M_AXIS_TREADY (tready),
      .M_AXIS_TLAST  (tlast),
      .irq           (irq)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic sb_push(input logic [31:0] d, input logic last);
      sb.push_back({d, last});
   endtask

   task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
      int n;
      @(posedge clk); #1;
      awaddr = addr; wdata = data; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!awready && n < 20);
      check("aw_w_ready", 64'({awready, wready}), 64'b11);
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!bvalid && n < 20);
      check("bvalid_bresp", 64'({bvalid, bresp}), 64'b100);
      @(posedge clk); #1;
   endtask

   task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
      int n;
      @(posedge clk); #1;
      araddr = addr; arvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!arready && n < 20);
      @(posedge clk); #1;
      arvalid = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!rvalid && n < 20);
      check("rvalid_rresp", 64'({rvalid, rresp}), 64'b100);
      data = rdata;
      @(posedge clk); #1;
   endtask

   task automatic read_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
      logic [31:0] d;
      axi_read(addr, d);
      check(tag, 64'(d), 64'(exp));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((sb.size() != 0 || tvalid) && n < 400) begin @(negedge clk); n++; end
      check(tag, 64'(sb.size()), 64'd0);
   endtask

   task automatic wait_tvalid(input string tag);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end while (!tvalid && n < 20);
      check(tag, 64'(tvalid), 64'd1);
   endtask

   // Stream scoreboard: every TVALID cycle must present the queue head;
   // the head is retired only on a TVALID&TREADY handshake.
   always @(negedge clk) begin
      if (rst_n && tvalid) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL unexpected_beat observed=%0h expected=none", {tdata, tlast});
         end else begin
            check("stream_beat", 64'({tdata, tlast}), 64'(sb[0]));
            if (tready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset_outputs",
            64'({awready, wready, bvalid, arready, rvalid, rdata, tvalid, tlast, irq}), 64'd0);
      read_check("reset_status", 5'h04, 32'h0000_0004);

      // Basic packet: LEN=4, START
      axi_write(5'h00, 32'h0000_0401);
      for (int unsigned i = 0; i < 4; i++) begin
         axi_write(5'h08, 32'hA0 + i);
         sb_push(32'hA0 + i, i == 3);
      end
      axi_write(5'h0C, 32'h0);
      drain("t1_drain");
      read_check("t1_status", 5'h04, 32'h0000_0024);
      axi_write(5'h04, 32'h0000_0020);

      // Overflow: 17 writes into a 16-deep FIFO with IE_OVF
      axi_write(5'h00, 32'h0000_0008);
      for (int unsigned i = 0; i < 17; i++) axi_write(5'h08, 32'hB0 + i);
      read_check("t2_status_full", 5'h04, 32'h0000_100A);
      check("t2_irq_set", 64'(irq), 64'd1);
      axi_write(5'h04, 32'h0000_0002);
      read_check("t2_status_clr", 5'h04, 32'h0000_1008);
      check("t2_irq_clr", 64'(irq), 64'd0);
      // LEN=255 clamps to 16; exactly the first 16 words must emerge
      for (int unsigned i = 0; i < 16; i++) sb_push(32'hB0 + i, i == 15);
      axi_write(5'h00, 32'h0000_FF01);
      axi_write(5'h0C, 32'h0);
      drain("t2_drain");
      read_check("t2_status_end", 5'h04, 32'h0000_0024);
      axi_write(5'h04, 32'h0000_0020);

      // Deferred start: START with level 1 < LEN 3
      axi_write(5'h00, 32'h0000_0301);
      axi_write(5'h08, 32'hC0);
      sb_push(32'hC0, 1'b0);
      axi_write(5'h0C, 32'h0);
      read_check("t3_pending", 5'h04, 32'h0000_0110);
      check("t3_no_tvalid", 64'(tvalid), 64'd0);
      axi_write(5'h08, 32'hC1);
      sb_push(32'hC1, 1'b0);
      axi_write(5'h08, 32'hC2);
      sb_push(32'hC2, 1'b1);
      drain("t3_drain");
      read_check("t3_status", 5'h04, 32'h0000_0024);
      axi_write(5'h04, 32'h0000_0020);

      // AUTO_START, LEN=2, stalled stream
      tready = 1'b0;
      axi_write(5'h00, 32'h0000_0202);
      for (int unsigned i = 0; i < 6; i++) begin
         axi_write(5'h08, 32'hD0 + i);
         sb_push(32'hD0 + i, i[0]);
      end
      axi_write(5'h00, 32'h0000_0203);
      repeat (40) begin @(posedge clk); #1 tready = ~tready; end
      tready = 1'b1;
      drain("t4_drain");
      read_check("t4_status", 5'h04, 32'h0000_0024);
      axi_write(5'h04, 32'h0000_0020);

      // FLUSH and LEN rewrite during SEND do not truncate the packet
      tready = 1'b0;
      axi_write(5'h00, 32'h0000_0401);
      for (int unsigned i = 0; i < 6; i++) begin
         axi_write(5'h08, 32'hE0 + i);
         if (i < 4) sb_push(32'hE0 + i, i == 3);
      end
      axi_write(5'h0C, 32'h0);
      wait_tvalid("t5_launch");
      @(posedge clk); #1 tready = 1'b1;
      @(posedge clk); #1 tready = 1'b0;
      axi_write(5'h00, 32'h0000_0811);
      tready = 1'b1;
      drain("t5_drain");
      read_check("t5_status", 5'h04, 32'h0000_0024);
      read_check("t5_ctrl", 5'h00, 32'h0000_0801);
      check("sb_empty", 64'(sb.size()), 64'd0);

      // Asynchronous reset mid-packet (done still set, IE_DONE on)
      axi_write(5'h00, 32'h0000_0405);
      check("t6_irq_done", 64'(irq), 64'd1);
      tready = 1'b0;
      for (int unsigned i = 0; i < 4; i++) begin
         axi_write(5'h08, 32'hF0 + i);
         sb_push(32'hF0 + i, i == 3);
      end
      axi_write(5'h0C, 32'h0);
      wait_tvalid("t6_launch");
      @(posedge clk); #1 tready = 1'b1;
      @(posedge clk); #1 tready = 1'b0;
      @(negedge clk); #2 rst_n = 1'b0;
      #1;
      check("t6_async_tvalid", 64'(tvalid), 64'd0);
      check("t6_async_irq", 64'(irq), 64'd0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      tready = 1'b1;
      read_check("t6_ctrl", 5'h00, 32'h0000_0000);
      read_check("t6_status", 5'h04, 32'h0000_0004);
      check("t6_tvalid_idle", 64'(tvalid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
